float_to_fixed_theta: RTL and testbench

//  Converts an IEEE-754 single-precision angle into the signed fixed-point

---
 rtl/float_to_fixed_theta.sv | 135 +++++++++++++
 tb/tb_float_to_fixed_theta.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_theta.sv
// IEEE-754 single-precision angle to signed fixed-point theta for the CORDIC core.
// Mantissa alignment is a 1-bit/cycle shifter, so latency follows the exponent.
module float_to_fixed_theta #(
  parameter int WIDTH     = 23,
  parameter int FRAC_BITS = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [31:0]      float_in,
  output logic             done,
  output logic [WIDTH-1:0] fixed_out,
  output logic             sat,
  output logic             invalid
);

  localparam int MW         = 24;
  localparam int CW         = 5;
  localparam int SHIFT_BASE = (WIDTH - FRAC_BITS) + 127;
  localparam int XW         = (WIDTH > MW + 1) ? WIDTH : MW + 1;
  localparam logic [WIDTH-1:0] MAX_MAG  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [XW-1:0]    MAX_WIDE = XW'(MAX_MAG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [MW-1:0]    r_acc;
  logic             r_guard;
  logic             r_sign;
  logic             r_sat_pend;
  logic             r_inv_pend;

  logic [7:0]       w_exp;
  int               w_n;
  logic             w_is_special;
  logic             w_is_zero;
  logic             w_is_sat;
  logic             w_is_tiny;
  logic             w_fast;
  logic [MW:0]      w_mag_raw;
  logic [XW-1:0]    w_mag_wide;
  logic             w_ovf;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_result;

  assign w_exp        = float_in[30:23];
  assign w_n          = SHIFT_BASE - int'(w_exp);
  assign w_is_special = (w_exp == 8'hff);
  assign w_is_zero    = (w_exp == 8'h00);
  assign w_is_sat     = (w_n <= 1);
  assign w_is_tiny    = (w_n > MW);
  assign w_fast       = w_is_special | w_is_zero | w_is_sat | w_is_tiny;

  // Inputs just below the saturation threshold can round up into the sign bit.
  assign w_mag_raw  = {1'b0, r_acc} + (MW+1)'(r_guard);
  assign w_mag_wide = XW'(w_mag_raw);
  assign w_ovf      = (w_mag_wide > MAX_WIDE);
  assign w_mag      = (r_sat_pend || w_ovf) ? MAX_MAG : WIDTH'(w_mag_wide);
  assign w_result   = r_sign ? (~w_mag + WIDTH'(1)) : w_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_fast ? S_ROUND : S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_guard    <= 1'b0;
      r_sign     <= 1'b0;
      r_sat_pend <= 1'b0;
      r_inv_pend <= 1'b0;
      done       <= 1'b0;
      fixed_out  <= '0;
      sat        <= 1'b0;
      invalid    <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign     <= float_in[31];
            r_guard    <= 1'b0;
            sat        <= 1'b0;
            invalid    <= 1'b0;
            r_inv_pend <= w_is_special;
            r_sat_pend <= !w_is_special && !w_is_zero && w_is_sat;
            if (w_fast) begin
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc <= {1'b1, float_in[22:0]};
              r_cnt <= CW'(w_n);
            end
          end
        end
        S_SHIFT: begin
          r_guard <= r_acc[0];
          r_acc   <= r_acc >> 1;
          r_cnt   <= r_cnt - CW'(1);
        end
        S_ROUND: begin
          fixed_out <= w_result;
          sat       <= r_sat_pend | w_ovf;
          invalid   <= r_inv_pend;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed_theta.sv
// Directed self-checking bench for float_to_fixed_theta (default Q1.21, 23-bit).
// Expected values are hand-computed from the float encodings.
module tb_float_to_fixed_theta;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] float_in;
  logic        done;
  logic [22:0] fixed_out;
  logic        sat;
  logic        invalid;

  int n_checks = 0;
  int n_fail   = 0;

  float_to_fixed_theta #(.WIDTH(23), .FRAC_BITS(21)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .float_in  (float_in),
    .done      (done),
    .fixed_out (fixed_out),
    .sat       (sat),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one conversion and wait (bounded) for done; lat counts enabled edges.
  task automatic conv(input logic [31:0] f, output logic [22:0] res,
                      output logic o_sat, output logic o_inv, output int lat);
    start    = 1'b1;
    float_in = f;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res   = fixed_out;
    o_sat = sat;
    o_inv = invalid;
  endtask

  task automatic test_reset;
    reset = 1'b0; clk_en = 1'b1; start = 1'b0; float_in = 32'h0;
    #12;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (fixed_out !== 23'h0) begin n_fail++; $display("FAIL reset_fixed got %h want 000000", fixed_out); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", sat); end
    n_checks++; if (invalid !== 1'b0) begin n_fail++; $display("FAIL reset_invalid got %b want 0", invalid); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal;
    logic [31:0] vin  [6] = '{32'h3f800000, 32'hbf800000, 32'h3f000000, 32'h34800000, 32'h35400000, 32'hb5400000};
    logic [22:0] vexp [6] = '{23'h200000, 23'h600000, 23'h100000, 23'h000001, 23'h000002, 23'h7ffffe};
    int          vlat [6] = '{4, 4, 5, 26, 25, 25};
    logic [22:0] res; logic s, v; int lat;
    for (int i = 0; i < 6; i++) begin
      conv(vin[i], res, s, v, lat);
      n_checks++; if (res !== vexp[i]) begin n_fail++; $display("FAIL normal_value[%0d] in=%h got %h want %h", i, vin[i], res, vexp[i]); end
      n_checks++; if (lat !== vlat[i]) begin n_fail++; $display("FAIL normal_latency[%0d] got %0d want %0d", i, lat, vlat[i]); end
      n_checks++; if ({s, v} !== 2'b00) begin n_fail++; $display("FAIL normal_flags[%0d] sat/inv got %b want 00", i, {s, v}); end
    end
  endtask

  task automatic test_saturate;
    logic [22:0] res; logic s, v; int lat;
    conv(32'h40000000, res, s, v, lat);
    n_checks++; if (res !== 23'h3fffff) begin n_fail++; $display("FAIL sat_pos_value got %h want 3fffff", res); end
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag got %b want 1", s); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sat_pos_latency got %0d want 2", lat); end
    conv(32'hc0400000, res, s, v, lat);
    n_checks++; if (res !== 23'h400001) begin n_fail++; $display("FAIL sat_neg_value got %h want 400001", res); end
    n_checks++; if ({s, v} !== 2'b10) begin n_fail++; $display("FAIL sat_neg_flags got %b want 10", {s, v}); end
  endtask

  task automatic test_special;
    logic [31:0] vin  [6] = '{32'h7fc00000, 32'h7f800000, 32'h00000000, 32'h80000000, 32'h00000001, 32'h34000000};
    logic        vinv [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [22:0] res; logic s, v; int lat;
    for (int i = 0; i < 6; i++) begin
      conv(vin[i], res, s, v, lat);
      n_checks++; if (res !== 23'h0) begin n_fail++; $display("FAIL special_value[%0d] in=%h got %h want 000000", i, vin[i], res); end
      n_checks++; if ({s, v} !== {1'b0, vinv[i]}) begin n_fail++; $display("FAIL special_flags[%0d] got %b want %b", i, {s, v}, {1'b0, vinv[i]}); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL special_latency[%0d] got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_clk_en;
    logic [22:0] res; logic s, v; int lat;
    conv(32'hbf800000, res, s, v, lat);
    start = 1'b1; float_in = 32'h3f800000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clk_en = 1'b0; start = 1'b1; float_in = 32'h40000000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clken_frozen_done got %b want 0", done); end
    n_checks++; if (fixed_out !== 23'h600000) begin n_fail++; $display("FAIL clken_frozen_fixed got %h want 600000", fixed_out); end
    clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clken_edge3_done got %b want 0", done); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clken_edge4_done got %b want 1", done); end
    n_checks++; if (fixed_out !== 23'h200000) begin n_fail++; $display("FAIL clken_result got %h want 200000", fixed_out); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL clken_busy_start_sat got %b want 0", sat); end
    clk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clken_done_hold got %b want 1", done); end
    clk_en = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clken_done_clear got %b want 0", done); end
  endtask

  task automatic test_reset_mid;
    logic [22:0] res; logic s, v; int lat;
    start = 1'b1; float_in = 32'h3f000000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
    n_checks++; if (fixed_out !== 23'h0) begin n_fail++; $display("FAIL rstmid_fixed got %h want 000000", fixed_out); end
    @(posedge clk); #1;
    reset = 1'b1;
    lat = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL rstmid_no_stray_done got %0d dones want 0", lat); end
    conv(32'h3f800000, res, s, v, lat);
    n_checks++; if (res !== 23'h200000 || lat !== 4) begin n_fail++; $display("FAIL rstmid_after got %h lat %0d want 200000 lat 4", res, lat); end
  endtask

  task automatic test_back_to_back;
    logic [22:0] res; logic s, v; int lat;
    conv(32'h3f000000, res, s, v, lat);
    n_checks++; if (res !== 23'h100000 || done !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %h done %b want 100000 done 1", res, done); end
    conv(32'hbf800000, res, s, v, lat);
    n_checks++; if (res !== 23'h600000) begin n_fail++; $display("FAIL b2b_second_value got %h want 600000", res); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 4", lat); end
    conv(32'h40000000, res, s, v, lat);
    conv(32'h3f000000, res, s, v, lat);
    n_checks++; if ({res, s} !== {23'h100000, 1'b0} || lat !== 5) begin n_fail++; $display("FAIL b2b_after_sat got %h sat %b lat %0d want 100000 sat 0 lat 5", res, s, lat); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturate();
    test_special();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
